// File: rtl/act_interp_pipe.sv
// Piecewise-linear activation: index+fraction split, two-entry table lookup, linear interpolation.
// Latency 3 cycles from accept to out_valid; throughput 1 sample/cycle.
// Backpressure: one global enable stalls every stage while out_valid & !out_ready; bubbles are kept.
module act_interp_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_y,
    input  logic                       tbl_we,
    input  logic [DATA_W-FRAC_W-1:0]   tbl_addr,
    input  logic [DATA_W-1:0]          tbl_wdata
);

    localparam int ADDR_W = DATA_W - FRAC_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = DATA_W + FRAC_W + 2;

    logic                en;

    logic [DATA_W-1:0]   tbl_q [DEPTH];
    logic [DATA_W-1:0]   tbl_d [DEPTH];

    logic                v1_q, v1_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [FRAC_W-1:0]   frac1_q, frac1_d;

    logic                v2_q, v2_d;
    logic [DATA_W-1:0]   base2_q, base2_d;
    logic [DATA_W-1:0]   next2_q, next2_d;
    logic [FRAC_W-1:0]   frac2_q, frac2_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_y_q, out_y_d;

    logic [DATA_W-1:0]        base_rd;
    logic [DATA_W-1:0]        next_rd;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] frac_ext;
    logic signed [PROD_W-1:0] base_ext;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        en       = !out_valid_q || out_ready;
        in_ready = en;

        tbl_d = tbl_q;
        if (tbl_we) begin
            tbl_d[tbl_addr] = tbl_wdata;
        end

        // Top entry has no successor: interpolate against itself rather than wrap to entry 0.
        base_rd = tbl_q[addr1_q];
        next_rd = (&addr1_q) ? base_rd : tbl_q[addr1_q + ADDR_W'(1)];

        diff     = $signed({next2_q[DATA_W-1], next2_q}) - $signed({base2_q[DATA_W-1], base2_q});
        diff_ext = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
        frac_ext = {{(PROD_W-FRAC_W){1'b0}}, frac2_q};
        base_ext = {{(PROD_W-DATA_W){base2_q[DATA_W-1]}}, base2_q};
        prod     = diff_ext * frac_ext;

        v1_d        = v1_q;
        addr1_d     = addr1_q;
        frac1_d     = frac1_q;
        v2_d        = v2_q;
        base2_d     = base2_q;
        next2_d     = next2_q;
        frac2_d     = frac2_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;

        if (en) begin
            v1_d = in_valid;
            if (in_valid) begin
                addr1_d = {~in_x[DATA_W-1], in_x[DATA_W-2:FRAC_W]};
                frac1_d = in_x[FRAC_W-1:0];
            end
            v2_d        = v1_q;
            base2_d     = base_rd;
            next2_d     = next_rd;
            frac2_d     = frac1_q;
            out_valid_d = v2_q;
            // Result lies between base and next, so dropping the upper bits is lossless.
            out_y_d     = DATA_W'(base_ext + (prod >>> FRAC_W));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
            v1_q        <= 1'b0;
            addr1_q     <= '0;
            frac1_q     <= '0;
            v2_q        <= 1'b0;
            base2_q     <= '0;
            next2_q     <= '0;
            frac2_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
        end else begin
            tbl_q       <= tbl_d;
            v1_q        <= v1_d;
            addr1_q     <= addr1_d;
            frac1_q     <= frac1_d;
            v2_q        <= v2_d;
            base2_q     <= base2_d;
            next2_q     <= next2_d;
            frac2_q     <= frac2_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;

endmodule

// File: tb/tb_act_interp_pipe.sv
// Directed bench for act_interp_pipe: driver pushes hand-computed results, monitor pops on each output handshake.
module tb_act_interp_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic [7:0] tbl_wdata;

    act_interp_pipe #(.DATA_W(8), .FRAC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y;
        int acc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   held_vld = 1'b0;
    int   held_y   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares every output handshake and the hold-while-stalled rule.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                check("stall_hold_valid", int'(out_valid), 1);
                check("stall_hold_y", int'($signed(out_y)), held_y);
            end
            held_vld = out_valid && !out_ready;
            held_y   = int'($signed(out_y));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", int'($signed(out_y)), -999);
                end else begin
                    e = sb.pop_front();
                    check("out_y", int'($signed(out_y)), e.y);
                    if (e.lat) check("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input int y, input bit lat);
        exp_t e;
        bit   done;
        in_valid = 1'b1;
        in_x     = x;
        done     = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.y   = y;
                e.acc = cyc;
                e.lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic write_tbl(input logic [3:0] a, input logic [7:0] d);
        tbl_we    = 1'b1;
        tbl_addr  = a;
        tbl_wdata = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            tick();
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic load_relu();
        for (int i = 0; i < 16; i++) begin
            write_tbl(4'(i), (i > 8) ? 8'((i - 8) * 16) : 8'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_y", int'(out_y), 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_idle_valid", int'(out_valid), 0);

        load_relu();
        send(8'h25, 37, 1'b1);
        drain();
        send(8'hEC, 0, 1'b1);
        send(8'h7F, 112, 1'b0);
        drain();

        write_tbl(4'd0, 8'h9C);
        write_tbl(4'd1, 8'hC4);
        send(8'h88, -80, 1'b0);
        send(8'h8F, -63, 1'b0);
        drain();

        write_tbl(4'd10, 8'd50);
        write_tbl(4'd11, 8'd20);
        send(8'h25, 40, 1'b0);
        send(8'h2F, 21, 1'b0);
        drain();

        // A write landing in the same cycle as the S2 read must not be seen by that sample.
        write_tbl(4'd10, 8'd32);
        write_tbl(4'd11, 8'd48);
        send(8'h25, 37, 1'b0);
        write_tbl(4'd10, 8'd0);
        send(8'h25, 15, 1'b0);
        drain();
        write_tbl(4'd10, 8'd32);

        fork
            begin
                for (int i = 0; i < 10; i++) send(8'(i), i, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        send(8'h25, 37, 1'b0);
        send(8'h7F, 112, 1'b0);
        send(8'h30, 48, 1'b0);
        rst = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_y", int'(out_y), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("postrst_in_ready", int'(in_ready), 1);
        check("postrst_out_valid", int'(out_valid), 0);
        send(8'h25, 0, 1'b0);
        send(8'h7F, 0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
